// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcode constants, flag indices and FSM states for the shared ALU.
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - integer ALU; C is the carry out of A+B or A+~B+1 (set means no borrow).
module alu
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};

  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      ALU_ADD: begin
        result         = sum[XLEN-1:0];
        flags[FLAG_C]  = sum[XLEN];
        flags[FLAG_V]  = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        result         = diff[XLEN-1:0];
        flags[FLAG_C]  = diff[XLEN];
        flags[FLAG_V]  = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, diff[XLEN-1]};
      default: result = '0;
    endcase
    flags[FLAG_N] = result[XLEN-1];
    flags[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick; `last` is the requester granted most recently.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = valid0 | valid1;
  // On a tie requester 1 wins only if requester 0 was granted last.
  assign grant_id    = valid1 & (~valid0 | ~last);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters with a single-entry response buffer.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [2:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [2:0]      req1_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic [3:0]      rsp_flags,
  output logic            rsp_err
);

  state_t          state, state_nxt;
  logic            last_id;
  logic [XLEN-1:0] op_a, op_b;
  logic [2:0]      op_code;
  logic            op_id;
  logic            grant_valid, grant_id;
  logic            window, take;
  logic [XLEN-1:0] alu_result;
  logic [3:0]      alu_flags;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last        (last_id),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (op_code),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // RESP with rsp_ready open the window too, so a new op can enter while the old one leaves.
  assign window     = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
  assign take       = !rst && window && grant_valid;
  assign req0_ready = take && !grant_id;
  assign req1_ready = take && grant_id;
  assign rsp_valid  = (state == ST_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (take) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = take ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_id    <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      op_id      <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        op_a    <= grant_id ? req1_a  : req0_a;
        op_b    <= grant_id ? req1_b  : req0_b;
        op_code <= grant_id ? req1_op : req0_op;
        op_id   <= grant_id;
        last_id <= grant_id;
      end
      if (state == ST_EXEC) begin
        rsp_id <= op_id;
        if (is_legal_op(op_code)) begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_err    <= 1'b0;
        end else begin
          rsp_result <= '0;
          rsp_flags  <= '0;
          rsp_err    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  alu_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
  } resp_t;

  function automatic void chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference arithmetic with wide integers: carry = no unsigned wrap / no borrow, V = signed range exceeded.
  function automatic resp_t model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    resp_t r;
    longint sa, sb, s;
    longint unsigned ua, ub;
    logic [31:0] d;
    logic c, v;
    sa = $signed(a); sb = $signed(b);
    ua = a; ub = b;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      3'b000: begin
        s = sa + sb; r.res = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b001: begin
        s = sa - sb; r.res = 32'(ua - ub); c = (ua >= ub);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b010: r.res = a & b;
      3'b011: r.res = a | b;
      3'b101: begin d = a - b; r.res = {31'd0, d[31]}; end
      default: begin r.err = 1'b1; return r; end
    endcase
    r.flags = {r.res[31], r.res == 32'd0, c, v};
    return r;
  endfunction

  // Model state: at most one op in flight, visible as a response from the second cycle after its accept edge.
  logic  pend = 1'b0;
  int    pend_edge = 0;
  resp_t pexp;
  logic  pid;
  logic  last = 1'b1;
  logic  ev, win, e0, e1;

  always @(negedge clk) begin
    if (ncyc > 0) begin
      ev = pend && (ncyc >= pend_edge + 1);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_id", rsp_id, pid);
        chk("rsp_result", rsp_result, pexp.res);
        chk("rsp_flags", rsp_flags, pexp.flags);
        chk("rsp_err", rsp_err, pexp.err);
      end
      win = !rst && (!pend || (ev && rsp_ready));
      e0 = win && req0_valid && (!req1_valid || last);
      e1 = win && req1_valid && (!req0_valid || !last);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      if (rst) begin
        pend = 1'b0;
        last = 1'b1;
      end else begin
        if (ev && rsp_ready) pend = 1'b0;
        if (e0 || e1) begin
          pend = 1'b1;
          pend_edge = ncyc + 1;
          pid = e1;
          pexp = e1 ? model_alu(req1_op, req1_a, req1_b) : model_alu(req0_op, req0_a, req0_b);
          last = e1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ok;
    ok = 1'b0;
    set_req(id, 1'b1, op, a, b);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", ok, 1);
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic single(input string name, input logic id, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] xr, input logic [3:0] xf, input logic xe);
    rsp_ready = 1'b1;
    issue(id, op, a, b);
    @(negedge clk);
    chk({name, "_exec_valid"}, rsp_valid, 0);
    @(negedge clk);
    chk({name, "_valid"}, rsp_valid, 1);
    chk({name, "_id"}, rsp_id, id);
    chk({name, "_result"}, rsp_result, xr);
    chk({name, "_flags"}, rsp_flags, xf);
    chk({name, "_err"}, rsp_err, xe);
    tick();
  endtask

  logic        grants[$];
  logic        r_id[$];
  logic [31:0] r_res[$];
  logic [3:0]  r_flg[$];

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    set_req(0, 1'b1, 3'b000, 0, 0);
    set_req(1, 1'b1, 3'b000, 0, 0);
    repeat (2) tick();
    set_req(0, 1'b0, 3'b000, 0, 0);
    set_req(1, 1'b0, 3'b000, 0, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_flags", rsp_flags, 0);
    chk("reset_rsp_err", rsp_err, 0);
    tick();

    // Tie right after reset: requester 0 first, then strict alternation.
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 3'b001, 32'd3, 32'd5);
    set_req(1, 1'b1, 3'b011, 32'hF0, 32'h0F);
    for (int i = 0; i < 40 && grants.size() < 6; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        r_id.push_back(rsp_id); r_res.push_back(rsp_result); r_flg.push_back(rsp_flags);
      end
      if (req0_ready) grants.push_back(1'b0);
      if (req1_ready) grants.push_back(1'b1);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    chk("tie_grant_count", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++) chk($sformatf("tie_grant%0d", i), grants[i], i % 2);
    chk("tie_resp_count_ge2", r_id.size() >= 2, 1);
    if (r_id.size() >= 2) begin
      chk("tie_first_id", r_id[0], 0);
      chk("tie_first_result", r_res[0], 32'hFFFF_FFFE);
      chk("tie_first_n", r_flg[0][3], 1);
      chk("tie_second_id", r_id[1], 1);
      chk("tie_second_result", r_res[1], 32'h0000_00FF);
    end

    single("add5_7", 0, 3'b000, 32'd5, 32'd7, 32'd12, 4'b0000, 0);
    single("add_ovf", 1, 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 0);
    single("sub_zero", 0, 3'b001, 32'd5, 32'd5, 32'd0, 4'b0110, 0);
    single("illegal", 1, 3'b111, 32'd9, 32'd9, 32'd0, 4'b0000, 1);
    single("slt", 0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000, 0);

    // Backpressure: response held for 4 cycles, pending request granted on release.
    rsp_ready = 1'b0;
    issue(0, 3'b000, 32'd10, 32'd20);
    set_req(1, 1'b1, 3'b000, 32'd1, 32'd2);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 32'd30);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant1", req1_ready, 1);
    chk("bp_release_valid", rsp_valid, 1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_fast_exec_valid", rsp_valid, 0);
    @(negedge clk);
    chk("bp_second_valid", rsp_valid, 1);
    chk("bp_second_id", rsp_id, 1);
    chk("bp_second_result", rsp_result, 32'd3);
    tick();

    // Reset while EXEC: op discarded, pointer back to 1.
    issue(0, 3'b000, 32'd1, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_exec_no_rsp", rsp_valid, 0);
    end
    tick();
    set_req(0, 1'b1, 3'b000, 32'd2, 32'd2);
    set_req(1, 1'b1, 3'b000, 32'd3, 32'd3);
    @(negedge clk);
    chk("rst_tie_ready0", req0_ready, 1);
    chk("rst_tie_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      set_req(0, $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
      set_req(1, $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
      rsp_ready = $urandom_range(0, 9) < 7;
      tick();
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
